// File: rtl/aer_pkg.sv
// Shared definitions for the AER output arbiter.
//   aer_state_t    : arbiter FSM encoding (IDLE, LOAD, SEND, RELEASE)
//   AER_* params   : default source count, spike-vector width, derived widths
//   aer_pack_addr  : packs {source id, neuron index} into an event address
package aer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } aer_state_t;

  localparam int AER_NUM_SRC = 4;
  localparam int AER_SPK_W   = 8;
  localparam int AER_IDX_W   = $clog2(AER_SPK_W);
  localparam int AER_SRC_W   = $clog2(AER_NUM_SRC);
  localparam int AER_ADDR_W  = AER_SRC_W + AER_IDX_W;

  // Source id lands in the upper field, neuron index in the lower idx_w bits.
  // Callers truncate the result to their own address width.
  function automatic logic [31:0] aer_pack_addr(input logic [31:0] src,
                                                input logic [31:0] idx,
                                                input int unsigned idx_w);
    return (src << idx_w) | idx;
  endfunction

endpackage

// File: rtl/aer_prio_enc.sv
// Lowest-set-bit encoder.
//   vec    : input vector
//   idx    : index of the lowest set bit (0 when vec is zero)
//   any    : at least one bit of vec is set
//   single : exactly one bit of vec is set
module aer_prio_enc #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last one to win.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any    = |vec;
  // vec & (vec - 1) clears the lowest set bit; zero afterwards means one bit.
  assign single = any && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/aer_arbiter.sv
// Round-robin arbiter that serialises per-tile spike vectors onto one AER bus.
//   CLK, RST      : clock, synchronous active-high reset
//   REQ / ACK     : per-source 4-phase handshake (ACK one-hot or zero)
//   SPIKES        : per-source spike vectors, source i at [i*SPK_W +: SPK_W]
//   AER_VALID/READY/ADDR/LAST : output event stream, ADDR = {src id, neuron}
//   BUSY          : arbiter not idle
//   DBG_STATE     : current FSM state
// Event stream handshake: an event transfers on a rising edge where
// AER_VALID and AER_READY are both high; while AER_VALID is high and
// AER_READY low, AER_VALID/AER_ADDR/AER_LAST hold their values, and
// AER_VALID only falls after a transfer (or on reset).
// All outputs decode registered state only; no input reaches an output
// combinationally.
module aer_arbiter
  import aer_pkg::*;
#(
  parameter int NUM_SRC = AER_NUM_SRC,
  parameter int SPK_W   = AER_SPK_W,
  parameter int IDX_W   = $clog2(SPK_W),
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC-1:0]       REQ,
  input  logic [NUM_SRC*SPK_W-1:0] SPIKES,
  output logic [NUM_SRC-1:0]       ACK,
  output logic                     AER_VALID,
  input  logic                     AER_READY,
  output logic [SRC_W+IDX_W-1:0]   AER_ADDR,
  output logic                     AER_LAST,
  output logic                     BUSY,
  output logic [1:0]               DBG_STATE
);

  localparam int ADDR_W = SRC_W + IDX_W;

  aer_state_t       state, nxt_state;
  logic [SRC_W-1:0] rr_ptr, nxt_rr;
  logic [SRC_W-1:0] gnt_id, nxt_gnt;
  logic [SPK_W-1:0] spk_reg, nxt_spk;
  logic [SPK_W-1:0] spk_slice;

  logic [NUM_SRC-1:0] req_rot;
  logic [SRC_W-1:0]   rot_idx;
  logic [SRC_W-1:0]   grant_id;
  logic               req_any;
  logic               req_single_unused;

  logic [IDX_W-1:0] spk_idx;
  logic             spk_any_unused;
  logic             spk_single;

  // Rotate REQ so the round-robin pointer position becomes bit 0; the lowest
  // set bit of the rotated vector is then the first requester at/after RR_PTR.
  always_comb begin
    req_rot = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      int k;
      k = j + int'(rr_ptr);
      if (k >= NUM_SRC) k = k - NUM_SRC;
      req_rot[j] = REQ[k];
    end
  end

  aer_prio_enc #(.W(NUM_SRC), .IW(SRC_W)) u_req_enc (
    .vec    (req_rot),
    .idx    (rot_idx),
    .any    (req_any),
    .single (req_single_unused)
  );

  // Undo the rotation to recover the absolute source id.
  always_comb begin
    int g;
    g = int'(rot_idx) + int'(rr_ptr);
    if (g >= NUM_SRC) g = g - NUM_SRC;
    grant_id = SRC_W'(g);
  end

  aer_prio_enc #(.W(SPK_W), .IW(IDX_W)) u_spk_enc (
    .vec    (spk_reg),
    .idx    (spk_idx),
    .any    (spk_any_unused),
    .single (spk_single)
  );

  assign spk_slice = SPIKES[int'(gnt_id)*SPK_W +: SPK_W];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      spk_reg <= '0;
    end else begin
      state   <= nxt_state;
      rr_ptr  <= nxt_rr;
      gnt_id  <= nxt_gnt;
      spk_reg <= nxt_spk;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_rr    = rr_ptr;
    nxt_gnt   = gnt_id;
    nxt_spk   = spk_reg;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          nxt_gnt   = grant_id;
          nxt_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        nxt_spk   = spk_slice;
        nxt_state = (|spk_slice) ? ST_SEND : ST_RELEASE;
      end
      ST_SEND: begin
        // REQ is deliberately not looked at here: a source dropping its
        // request mid-burst still gets the whole burst sent.
        if (AER_READY) begin
          nxt_spk = spk_reg & (spk_reg - SPK_W'(1));
          if (spk_single) nxt_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!REQ[gnt_id]) begin
          nxt_rr    = (int'(gnt_id) == NUM_SRC - 1) ? '0 : gnt_id + SRC_W'(1);
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ACK = '0;
    if (state == ST_RELEASE) ACK[gnt_id] = 1'b1;
  end

  assign AER_VALID = (state == ST_SEND);
  assign AER_LAST  = (state == ST_SEND) && spk_single;
  assign AER_ADDR  = (state == ST_SEND)
                   ? ADDR_W'(aer_pack_addr(32'(gnt_id), 32'(spk_idx), IDX_W))
                   : '1;
  assign BUSY      = (state != ST_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_aer_arbiter.sv
// Directed bench for aer_arbiter: single-source bursts, backpressure,
// round-robin fairness, zero vectors, pointer wrap and reset mid-burst.
// Expected events {last, addr} are queued as stimulus is set up and popped by
// a monitor whenever the DUT transfers an event.
module tb_aer_arbiter;
  import aer_pkg::*;

  localparam int W = 6;  // {AER_LAST, AER_ADDR[4:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] spikes = '0;
  logic        aer_ready = 1'b1;
  logic [3:0]  ack;
  logic        aer_valid;
  logic [4:0]  aer_addr;
  logic        aer_last;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  aer_arbiter dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .SPIKES    (spikes),
    .ACK       (ack),
    .AER_VALID (aer_valid),
    .AER_READY (aer_ready),
    .AER_ADDR  (aer_addr),
    .AER_LAST  (aer_last),
    .BUSY      (busy),
    .DBG_STATE (dbg_state)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_evt   = '0;

  always @(negedge clk) begin
    // Previous sample stalled with no reset pending: output must be unchanged.
    if (prev_stall) begin
      chk("stall_valid_held", 32'(aer_valid), 32'd1);
      chk("stall_evt_held", 32'({aer_last, aer_addr}), 32'(prev_evt));
    end
    if (!rst && aer_valid && aer_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'({aer_last, aer_addr}), 32'h3F);
      end else begin
        chk("event", 32'({aer_last, aer_addr}), 32'(exp_q.pop_front()));
      end
    end
    prev_stall <= !rst && aer_valid && !aer_ready;
    prev_evt   <= {aer_last, aer_addr};
  end

  // ---------------- driver tasks ----------------
  task automatic push_evt(input logic last, input int src, input int idx);
    exp_q.push_back({last, 2'(src), 3'(idx)});
  endtask

  task automatic set_slice(input int src, input logic [7:0] v);
    spikes[src*8 +: 8] = v;
  endtask

  // Wait for an ACK, confirm it targets src, drop REQ[src], confirm ACK falls.
  task automatic serve(input int src);
    bit got;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack != 4'b0) begin
        got = 1;
        break;
      end
    end
    chk("serve_ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("serve_ack_onehot", 32'(ack), 32'(1 << src));
      req[src] = 1'b0;
      tick();
      chk("serve_ack_drop", 32'(ack), 32'd0);
      chk("serve_idle", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(aer_valid), 32'd0);
    chk({tag, "_ack"},   32'(ack), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_last"},  32'(aer_last), 32'd0);
    chk({tag, "_addr"},  32'(aer_addr), 32'h1F);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single source, three events at one per cycle (0x00, 0x02, 0x07).
    set_slice(0, 8'b1000_0101);
    push_evt(0, 0, 0);
    push_evt(0, 0, 2);
    push_evt(1, 0, 7);
    req = 4'b0001;
    tick();
    chk("s1_load_valid", 32'(aer_valid), 32'd0);
    chk("s1_load_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_ev0", 32'({aer_valid, aer_last, aer_addr}), 32'({1'b1, 1'b0, 5'h00}));
    tick();
    chk("s1_ev1", 32'({aer_valid, aer_last, aer_addr}), 32'({1'b1, 1'b0, 5'h02}));
    tick();
    chk("s1_ev2", 32'({aer_valid, aer_last, aer_addr}), 32'({1'b1, 1'b1, 5'h07}));
    tick();
    chk("s1_rel_valid", 32'(aer_valid), 32'd0);
    chk("s1_rel_ack", 32'(ack), 32'b0001);
    tick();
    tick();
    chk("s1_ack_held", 32'(ack), 32'b0001);
    req = 4'b0000;
    tick();
    chk("s1_ack_drop", 32'(ack), 32'd0);
    chk("s1_idle", 32'(busy), 32'd0);

    // Backpressure: second event stalled for three cycles.
    push_evt(0, 0, 0);
    push_evt(0, 0, 2);
    push_evt(1, 0, 7);
    req = 4'b0001;
    tick();
    tick();
    chk("bp_ev0", 32'(aer_addr), 32'h00);
    tick();
    chk("bp_ev1", 32'(aer_addr), 32'h02);
    aer_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", 32'({aer_valid, aer_addr}), 32'({1'b1, 5'h02}));
    end
    aer_ready = 1'b1;
    tick();
    chk("bp_ev2", 32'({aer_last, aer_addr}), 32'({1'b1, 5'h07}));
    serve(0);

    // Round robin from pointer 0, then source 0 re-requests and goes last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_slice(i, 8'(1 << i));
    push_evt(1, 0, 0);
    push_evt(1, 1, 1);
    push_evt(1, 2, 2);
    push_evt(1, 3, 3);
    push_evt(1, 0, 0);
    req = 4'b1111;
    serve(0);
    req[0] = 1'b1;
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    chk("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero vector on source 2: ACK two cycles after REQ, no events.
    set_slice(2, 8'h00);
    req = 4'b0100;
    tick();
    chk("zv_load_ack", 32'(ack), 32'd0);
    tick();
    chk("zv_ack", 32'(ack), 32'b0100);
    chk("zv_valid", 32'(aer_valid), 32'd0);
    req = 4'b0000;
    tick();
    chk("zv_ack_drop", 32'(ack), 32'd0);
    // Pointer now 3: with sources 1 and 3 pending, source 3 wins.
    set_slice(1, 8'h02);
    set_slice(3, 8'h08);
    push_evt(1, 3, 3);
    push_evt(1, 1, 1);
    req = 4'b1010;
    serve(3);
    serve(1);

    // Wrap: source 3 alone, then 0 and 3 pending -> 0 first.
    push_evt(1, 3, 3);
    req = 4'b1000;
    serve(3);
    set_slice(0, 8'h01);
    push_evt(1, 0, 0);
    push_evt(1, 3, 3);
    req = 4'b1001;
    serve(0);
    serve(3);

    // Move pointer to 2 via a zero-vector grant on source 1.
    set_slice(1, 8'h00);
    req = 4'b0010;
    serve(1);

    // Reset during the second of three events on source 2.
    set_slice(2, 8'h07);
    push_evt(0, 2, 0);
    req = 4'b0100;
    tick();
    tick();
    chk("rb_ev0", 32'(aer_addr), 32'h10);
    tick();
    chk("rb_ev1", 32'(aer_addr), 32'h11);
    rst = 1'b1;
    aer_ready = 1'b0;
    req = 4'b0000;
    tick();
    check_reset_outputs("rb");
    rst = 1'b0;
    aer_ready = 1'b1;
    tick();
    chk("rb_quiet", 32'({aer_valid, ack}), 32'd0);
    // Pointer must be back at 0: with 1 and 2 pending, source 1 wins.
    set_slice(1, 8'h02);
    set_slice(2, 8'h01);
    push_evt(1, 1, 1);
    push_evt(1, 2, 0);
    req = 4'b0110;
    serve(1);
    serve(2);

    tick();
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
